// File: rtl/muldiv_if.sv
// muldiv_if: operand, MTHI/MTLO and result bundle between the control/EX
// stage (master) and the iterative multiply/divide unit (slave).
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative radix-2 multiply/divide unit with architectural HI/LO.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Operands are reduced to magnitudes
// on acceptance, 32 CALC steps run on a shared 64-bit accumulator, and a
// single FIX cycle applies the sign correction and writes HI/LO.
// Optional feature macro: MULDIV_DIV_EN. When it is undefined the divide
// datapath is removed; DIV/DIVU then pass IDLE->FIX->IDLE without touching
// HI/LO and dz stays low.
module muldiv (
    input  logic    clk,
    input  logic    rstn,
    muldiv_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic        r_isDiv;
    logic [63:0] r_acc;
    logic [31:0] r_magB;
    logic        r_negRes;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [32:0] w_mulSum;
    logic [63:0] w_mulNext;
    logic [63:0] w_prodFix;

    // Signed ops work on magnitudes; the sign is restored in FIX.
    assign w_signed  = ~bus.op[0];
    assign w_magA    = (w_signed & bus.A[31]) ? -bus.A : bus.A;
    assign w_magB    = (w_signed & bus.B[31]) ? -bus.B : bus.B;

    // Multiply step: the multiplier sits in the low half and is consumed
    // LSB-first while partial sums accumulate into the high half.
    assign w_mulSum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_magB} : 33'd0);
    assign w_mulNext = {w_mulSum, r_acc[31:1]};
    assign w_prodFix = r_negRes ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
    logic        r_negRem;
    logic [31:0] r_origA;
    logic [32:0] w_remShift;
    logic [32:0] w_diff;
    logic [63:0] w_divNext;
    logic [31:0] w_quoFix;
    logic [31:0] w_remFix;

    // Restoring divide step: the remainder lives in the high half, the
    // dividend shifts out of the low half while quotient bits shift in.
    // The shifted remainder needs 33 bits; a set bit 32 of the difference
    // means the trial subtraction went negative and is discarded.
    assign w_remShift = {r_acc[63:32], r_acc[31]};
    assign w_diff     = w_remShift - {1'b0, r_magB};
    assign w_divNext  = w_diff[32] ? {w_remShift[31:0], r_acc[30:0], 1'b0}
                                   : {w_diff[31:0],     r_acc[30:0], 1'b1};
    assign w_quoFix   = r_negRes ? -r_acc[31:0]  : r_acc[31:0];
    assign w_remFix   = r_negRem ? -r_acc[63:32] : r_acc[63:32];

    // Divide-only operand bookkeeping: remainder sign and original dividend
    // (returned in HI on a zero divisor).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_negRem <= 1'b0;
            r_origA  <= 32'd0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_negRem <= w_signed & bus.A[31];
            r_origA  <= bus.A;
        end
    end
`endif

    // Control FSM, iteration datapath and HI/LO/status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_isDiv  <= 1'b0;
            r_acc    <= 64'd0;
            r_magB   <= 32'd0;
            r_negRes <= 1'b0;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_isDiv  <= bus.op[1];
                        r_acc    <= {32'd0, w_magA};
                        r_magB   <= w_magB;
                        r_negRes <= w_signed & (bus.A[31] ^ bus.B[31]);
                        r_cnt    <= 6'd0;
                        r_busy   <= 1'b1;
`ifdef MULDIV_DIV_EN
                        r_dz     <= bus.op[1] & (bus.B == 32'd0);
                        r_state  <= S_CALC;
`else
                        r_dz     <= 1'b0;
                        r_state  <= bus.op[1] ? S_FIX : S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
`ifdef MULDIV_DIV_EN
                    r_acc <= r_isDiv ? w_divNext : w_mulNext;
`else
                    r_acc <= w_mulNext;
`endif
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!r_isDiv) begin
                        r_hi <= w_prodFix[63:32];
                        r_lo <= w_prodFix[31:0];
                    end
`ifdef MULDIV_DIV_EN
                    else if (r_dz) begin
                        r_hi <= r_origA;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_remFix;
                        r_lo <= w_quoFix;
                    end
`endif
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dz   = r_dz;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed-vector bench for muldiv. Issued operations push their
// hand-computed HI/LO/dz and expected done cycle into a scoreboard queue; a
// monitor pops and compares on every done pulse. Expectations for DIV/DIVU
// follow MULDIV_DIV_EN so the same bench covers both builds.
module tb_muldiv;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          doneCycle;
    } exp_t;

    exp_t        sbQueue[$];
    int          cycle = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] mHi;
    logic [31:0] mLo;

    // Free-running cycle count, stable between rising edges.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one operation at the current falling edge. Done is expected 34
    // cycles after issue (accept edge plus 33), or 2 cycles for a divide in a
    // build without the divider, where HI/LO must stay unchanged. Untracked
    // ops are ones that reset will kill before completion.
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input logic expDz, input bit track);
        exp_t e;
        int   lat;
        lat = 34;
`ifndef MULDIV_DIV_EN
        if (op[1]) begin
            lat   = 2;
            expHi = mHi;
            expLo = mLo;
            expDz = 1'b0;
            track = 1'b1;
        end
`endif
        if (track) begin
            e.tag       = tag;
            e.hi        = expHi;
            e.lo        = expLo;
            e.dz        = expDz;
            e.doneCycle = cycle + lat;
            sbQueue.push_back(e);
            mHi = expHi;
            mLo = expLo;
        end
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; busy must stay high until done and be low with it.
    task automatic waitDone(input string tag, input int limit);
        bit seen;
        bit busyOk;
        seen   = 1'b0;
        busyOk = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy !== 1'b1) busyOk = 1'b0;
        end
        checkOutput({tag, " done seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput({tag, " busy while running"}, {31'd0, busyOk}, 32'd1);
            checkOutput({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    // Scoreboard monitor: compare every done pulse against the queue head and
    // make sure done never lasts more than one cycle.
    initial begin
        exp_t e;
        logic prevDone;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn !== 1'b1) begin
                prevDone = 1'b0;
            end else begin
                if (prevDone) checkOutput("done single pulse", {31'd0, bus.done}, 32'd0);
                if (bus.done === 1'b1 && !prevDone) begin
                    if (sbQueue.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected done: got done=1 at cycle %0d, expected no pending op", cycle);
                    end else begin
                        e = sbQueue.pop_front();
                        checkOutput({e.tag, " hi"}, bus.hi, e.hi);
                        checkOutput({e.tag, " lo"}, bus.lo, e.lo);
                        checkOutput({e.tag, " dz"}, {31'd0, bus.dz}, {31'd0, e.dz});
                        checkOutput({e.tag, " done cycle"}, cycle, e.doneCycle);
                    end
                end
                prevDone = bus.done;
            end
        end
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected completion", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int   c;
        logic expDzHeld;
        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;
        mHi       = 32'd0;
        mLo       = 32'd0;
        repeat (2) @(negedge clk);

        checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset dz",   {31'd0, bus.dz},   32'd0);
        checkOutput("reset hi",   bus.hi, 32'd0);
        checkOutput("reset lo",   bus.lo, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // MTHI / MTLO in IDLE.
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.lo_we = 1'b0;
        checkOutput("mthi hi", bus.hi, 32'h1234_5678);
        checkOutput("mtlo lo", bus.lo, 32'h9ABC_DEF0);
        mHi = 32'h1234_5678;
        mLo = 32'h9ABC_DEF0;

        // MULT 7 * -3 = -21.
        applyStimulus("mult 7*-3", 2'b00, 32'd7, 32'hFFFF_FFFD,
                      32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        waitDone("mult 7*-3", 40);

        // MULTU max*max, then DIVU 100/7 issued in the done cycle.
        applyStimulus("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        waitDone("multu max", 40);
        applyStimulus("divu 100/7", 2'b11, 32'd100, 32'd7,
                      32'd2, 32'd14, 1'b0, 1'b1);
        waitDone("divu 100/7", 40);

        // Signed divides: negative dividend and the overflow case.
        applyStimulus("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        waitDone("div -7/2", 40);
        applyStimulus("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        waitDone("div min/-1", 40);

        // Divide by zero: dz holds until the next accepted start.
        applyStimulus("divu 100/0", 2'b11, 32'd100, 32'd0,
                      32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b1);
        waitDone("divu 100/0", 40);
        repeat (3) @(negedge clk);
`ifdef MULDIV_DIV_EN
        expDzHeld = 1'b1;
`else
        expDzHeld = 1'b0;
`endif
        checkOutput("dz held in idle", {31'd0, bus.dz}, {31'd0, expDzHeld});
        applyStimulus("mult -1*5", 2'b00, 32'hFFFF_FFFF, 32'd5,
                      32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b1);
        checkOutput("dz cleared by start", {31'd0, bus.dz}, 32'd0);
        waitDone("mult -1*5", 40);

        // start and MTLO while busy are both ignored.
        c = cycle;
        applyStimulus("mult 2*2", 2'b00, 32'd2, 32'd2,
                      32'd0, 32'd4, 1'b0, 1'b1);
        while (cycle < c + 10) @(negedge clk);
        bus.op    = 2'b00;
        bus.A     = 32'd3;
        bus.B     = 32'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cycle < c + 12) @(negedge clk);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h55;
        @(negedge clk);
        bus.lo_we = 1'b0;
        waitDone("mult 2*2", 40);

        // Reset in the middle of a DIV: no done, HI/LO cleared.
        c = cycle;
        applyStimulus("div reset", 2'b10, 32'd100, 32'd7,
                      32'd2, 32'd14, 1'b0, 1'b0);
        while (cycle < c + 15) @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("midop reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midop reset done", {31'd0, bus.done}, 32'd0);
        checkOutput("midop reset hi",   bus.hi, 32'd0);
        checkOutput("midop reset lo",   bus.lo, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        mHi  = 32'd0;
        mLo  = 32'd0;
        repeat (40) @(negedge clk);
        checkOutput("post reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("post reset lo",   bus.lo, 32'd0);

        applyStimulus("mult 6*7", 2'b00, 32'd6, 32'd7,
                      32'd0, 32'd42, 1'b0, 1'b1);
        waitDone("mult 6*7", 40);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", sbQueue.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
